// File: rtl/riscv_trace_buffer.sv
// Retire-trace capture buffer: records register write-back and data-memory events
// while armed, then drains them oldest-first through a valid/ready port.
module riscv_trace_buffer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 16,
    parameter int TS_W   = 16
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   reg_write_sig,
    input  logic [4:0]                             reg_num,
    input  logic [DATA_W-1:0]                      reg_data,
    input  logic                                   wr,
    input  logic                                   rd,
    input  logic [ADDR_W-1:0]                      addr,
    input  logic [DATA_W-1:0]                      wr_data,
    input  logic [DATA_W-1:0]                      rd_data,
    input  logic                                   halt,
    input  logic                                   arm,
    input  logic                                   stop,
    input  logic                                   clear,
    input  logic                                   wrap_en,
    output logic                                   out_valid,
    input  logic                                   out_ready,
    output logic [3+5+ADDR_W+2*DATA_W+TS_W-1:0]    out_entry,
    output logic [1:0]                             state,
    output logic [$clog2(DEPTH):0]                 count,
    output logic                                   overflow,
    output logic [TS_W-1:0]                        drop_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 3 + 5 + ADDR_W + 2*DATA_W + TS_W;

    typedef enum logic [1:0] {
        S_IDLE    = 2'b00,
        S_CAPTURE = 2'b01,
        S_DONE    = 2'b10
    } state_t;

    state_t             st;
    logic [EW-1:0]      mem [DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [TS_W-1:0]    ts;
    logic               evt;
    logic               full;
    logic               last_slot;
    logic               rd_fire;
    logic [DATA_W-1:0]  mem_data;
    logic [EW-1:0]      new_entry;

    always_comb begin
        mem_data = '0;
        if (wr)
            mem_data = wr_data;
        else if (rd)
            mem_data = rd_data;
    end

    assign evt       = reg_write_sig | wr | rd;
    assign full      = (count == CW'(DEPTH));
    assign last_slot = (count == CW'(DEPTH - 1));
    assign new_entry = {reg_write_sig, wr, rd, reg_num, addr, reg_data, mem_data, ts};

    assign state     = st;
    assign out_valid = (st == S_DONE) && (count != '0);
    assign out_entry = mem[rd_ptr];
    assign rd_fire   = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            st       <= S_IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
            ts       <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else begin
            case (st)
                S_IDLE: begin
                    if (arm) begin
                        st       <= S_CAPTURE;
                        wr_ptr   <= '0;
                        rd_ptr   <= '0;
                        count    <= '0;
                        overflow <= 1'b0;
                        drop_cnt <= '0;
                        ts       <= '0;
                    end
                end
                S_CAPTURE: begin
                    if (ts != '1)
                        ts <= ts + TS_W'(1);
                    if (halt || stop)
                        st <= S_DONE;
                    if (evt) begin
                        if (full && wrap_en) begin
                            // Keep-newest: slot under rd_ptr holds the oldest entry
                            mem[wr_ptr] <= new_entry;
                            wr_ptr      <= wr_ptr + PW'(1);
                            rd_ptr      <= rd_ptr + PW'(1);
                            overflow    <= 1'b1;
                            if (drop_cnt != '1)
                                drop_cnt <= drop_cnt + TS_W'(1);
                        end else if (full) begin
                            // wrap_en dropped while already full: nothing more fits
                            st <= S_DONE;
                        end else begin
                            mem[wr_ptr] <= new_entry;
                            wr_ptr      <= wr_ptr + PW'(1);
                            count       <= count + CW'(1);
                            if (!wrap_en && last_slot)
                                st <= S_DONE;
                        end
                    end else if (full && !wrap_en) begin
                        st <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (rd_fire) begin
                        rd_ptr <= rd_ptr + PW'(1);
                        count  <= count - CW'(1);
                    end
                end
                default: st <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/riscv_trace_buffer.md
# riscv_trace_buffer

Parametrised retire-trace capture unit for the RV32I core. It samples the core's per-cycle debug outputs (register write-back and data-memory access) into a DEPTH-entry on-chip buffer while armed. It stops on core halt, on a full buffer (stop mode) or on request, then drains the captured entries through a valid/ready read port. Compared with the core's raw debug pins, it adds configurable data/address widths, buffer depth, timestamping, and a wrap (keep-newest) mode.

## Interface
Parameters:
- DATA_W, 32, register/memory data width
- ADDR_W, 9, data-memory address width
- DEPTH, 16, buffer entries; power of two, ≥2
- TS_W, 16, timestamp and drop-counter width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- reg_write_sig  in  1  core register write this cycle
- reg_num  in  5  destination register
- reg_data  in  DATA_W  write-back data
- wr  in  1  data-memory write
- rd  in  1  data-memory read
- addr  in  ADDR_W  memory address
- wr_data  in  DATA_W  store data
- rd_data  in  DATA_W  load data
- halt  in  1  core halt asserted
- arm  in  1  start capture (accepted in IDLE only)
- stop  in  1  force end of capture
- clear  in  1  flush buffer, return to IDLE
- wrap_en  in  1  1 = overwrite oldest when full, 0 = stop when full
- out_valid  out  1  entry available
- out_ready  in  1  consumer accepts entry
- out_entry  out  3+5+ADDR_W+2*DATA_W+TS_W  {kind[2:0]={reg_write_sig,wr,rd}, reg_num, addr, reg_data, mem_data, ts}, MSB first
- state  out  2  00 IDLE, 01 CAPTURE, 10 DONE
- count  out  $clog2(DEPTH)+1  stored entries
- overflow  out  1  sticky; an entry was overwritten
- drop_cnt  out  TS_W  overwritten entries, saturating

## Operation
- Storage is a flop array indexed by wr_ptr/rd_ptr, each $clog2(DEPTH) bits, wrapping naturally.
- An event cycle is a cycle with reg_write_sig|wr|rd. Only event cycles in CAPTURE write an entry. mem_data = wr_data if wr, else rd_data if rd, else 0.
- ts: cleared on arm acceptance, +1 every CAPTURE cycle, saturates at all-ones; the entry stores ts before increment.
- FSM:
  - IDLE→CAPTURE on arm; ptrs, count, overflow, drop_cnt and ts are zeroed.
  - CAPTURE→DONE on halt, on stop, or when wrap_en=0 and the write makes count==DEPTH. arm is ignored in CAPTURE.
  - DONE holds until clear.
  - clear from any state→IDLE with all storage state zeroed. clear beats arm and stop in the same cycle.
- Full with wrap_en=1: the new entry overwrites mem[rd_ptr], both ptrs advance, count stays DEPTH, overflow←1, drop_cnt++ (saturating).
- Read port: out_valid = (state==DONE && count!=0). out_entry = mem[rd_ptr] combinationally. On out_valid&&out_ready: rd_ptr++, count--. out_ready is ignored outside DONE.
- Event on the halt/stop cycle is captured before entering DONE.
- Reset: state=IDLE, count=0, ptrs=0, overflow=0, drop_cnt=0, ts=0, out_valid=0, out_entry=0 (array cleared).

## Timing
- Capture: an event in cycle N while state==CAPTURE is visible in storage and count at N+1.
- Arm-accept cycle (state IDLE) is not captured; capture starts the following cycle with ts=0.
- halt/stop/full-stop at cycle N → state==DONE at N+1; out_valid may rise at N+1.
- Readout: zero-latency, one entry per cycle with out_ready held high; DEPTH entries drain in DEPTH cycles.
- Entries come out oldest-first; in wrap mode the first entry out is the oldest surviving one.
- Mid-capture reset or clear: next cycle IDLE, count=0, no partial entry retained.

## Test plan
- Stop mode, DEPTH=16: arm, then 20 consecutive register writes x1..x20 (data=i) → DONE after the 16th write, count=16, reads return x1..x16 with ts 0..15, overflow=0.
- Wrap mode: arm, 20 register writes, then halt → count=16, overflow=1, drop_cnt=4, first out_entry is x5, last is x20.
- Load cycle (reg_write_sig=1, rd=1, addr=0x040, rd_data=0xDEADBEEF) and store cycle (wr=1, wr_data=0x12345678), with idle cycles between → 2 entries, kind=3'b101 and 3'b010, mem_data correct, ts reflects the gaps.
- Backpressure: in DONE with count=4, toggle out_ready 1,0,1,1,1 → out_entry stable while stalled, count 4→3→3→2→1→0, out_valid=0 after.
- Same-cycle events: arm and clear together → stays IDLE. Event on the halt cycle → captured. reset asserted mid-capture with count=7 → IDLE, count=0, out_valid=0 next cycle.
